// File: rtl/cfg_fabric.sv
// cfg_fabric: splits one Avalon-MM config slave port across NUM_SLAVES
// downstream config slaves by decoding the upper address bits.
//
// Writes go straight through to the selected slave. Reads are tracked so that
// responses come back in order. A read to a different slave waits until every
// outstanding read has been answered. Slave responses that nothing is waiting
// for are dropped and counted.
//
// Optional feature macro: CFG_FABRIC_TIMEOUT_EN
//   defined   - read watchdog and FLUSH state are built in.
//   undefined - no watchdog; reads wait indefinitely; timeout_count reads 0.
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   avs_config_*                 upstream slave port (from the HPS config master)
//   avm_cfg_address              per-slave local address, ADDR_W-SEL_W bits each
//   avm_cfg_read/write           per-slave strobes
//   avm_cfg_writedata            write data, broadcast to all slaves
//   avm_cfg_waitrequest          per-slave stall
//   avm_cfg_readdata/valid       per-slave read response
//   timeout_count, drop_count    saturating event counters
//
// state | meaning
// IDLE  | no reads outstanding
// BUSY  | reads outstanding to slave cur_sel
// FLUSH | watchdog fired; returning ERR_DATA for each outstanding read
module cfg_fabric #(
    parameter int                NUM_SLAVES = 2,
    parameter int                ADDR_W     = 16,
    parameter int                SEL_W      = 4,
    parameter int                DATA_W     = 32,
    parameter int                MAX_PEND   = 4,
    parameter int                TIMEOUT    = 255,
    parameter logic [DATA_W-1:0] ERR_DATA   = DATA_W'(32'hBAD0_0000)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [ADDR_W-1:0]                      avs_config_address,
    input  logic                                   avs_config_read,
    input  logic                                   avs_config_write,
    input  logic [DATA_W-1:0]                      avs_config_writedata,
    output logic                                   avs_config_waitrequest,
    output logic [DATA_W-1:0]                      avs_config_readdata,
    output logic                                   avs_config_readdatavalid,
    output logic [NUM_SLAVES*(ADDR_W-SEL_W)-1:0]   avm_cfg_address,
    output logic [NUM_SLAVES-1:0]                  avm_cfg_read,
    output logic [NUM_SLAVES-1:0]                  avm_cfg_write,
    output logic [DATA_W-1:0]                      avm_cfg_writedata,
    input  logic [NUM_SLAVES-1:0]                  avm_cfg_waitrequest,
    input  logic [NUM_SLAVES*DATA_W-1:0]           avm_cfg_readdata,
    input  logic [NUM_SLAVES-1:0]                  avm_cfg_readdatavalid,
    output logic [7:0]                             timeout_count,
    output logic [7:0]                             drop_count
);
    localparam int LOC_W  = ADDR_W - SEL_W;
    localparam int PEND_W = $clog2(MAX_PEND + 1);

    typedef enum logic [1:0] {IDLE, BUSY, FLUSH} state_t;

    state_t              state, next_state;
    logic [PEND_W-1:0]   pend_cnt;
    logic [SEL_W-1:0]    cur_sel;
    logic                rdv_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [7:0]          drop_cnt;

    logic [SEL_W-1:0]    sel;
    logic [LOC_W-1:0]    loc_addr;
    logic                dec_err;
    logic                rd;
    logic                rd_stall;
    logic                slv_wait;
    logic                cur_rdv;
    logic [DATA_W-1:0]   cur_rdata;
    logic                resp_ok;
    logic                flush_resp;
    logic                pend_dec;
    logic                issue;
    logic                slv_issue;
    logic                err_issue;
    logic                drop_any;
    logic                wd_fire;

    assign sel      = avs_config_address[ADDR_W-1 -: SEL_W];
    assign loc_addr = avs_config_address[LOC_W-1:0];
    assign dec_err  = (int'(sel) >= NUM_SLAVES);
    // A simultaneous write takes priority; the read is ignored entirely.
    assign rd       = avs_config_read & ~avs_config_write;

    // A decode-error read is never a cur_sel match, so it also waits for pend_cnt==0.
    assign rd_stall = (pend_cnt == PEND_W'(MAX_PEND))
                    || ((pend_cnt != '0) && (sel != cur_sel))
                    || (state == FLUSH);

    always_comb begin
        slv_wait  = 1'b0;
        cur_rdv   = 1'b0;
        cur_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel == SEL_W'(i)) slv_wait = avm_cfg_waitrequest[i];
            if (cur_sel == SEL_W'(i)) begin
                cur_rdv   = avm_cfg_readdatavalid[i];
                cur_rdata = avm_cfg_readdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign resp_ok    = cur_rdv && (pend_cnt != '0) && (state != FLUSH);
    assign flush_resp = (state == FLUSH);
    assign pend_dec   = resp_ok | flush_resp;

    assign issue     = rd & ~rd_stall & (dec_err | ~slv_wait);
    assign slv_issue = issue & ~dec_err;
    // Decode-error reads are answered at the issue edge, so they never occupy pend_cnt.
    assign err_issue = issue & dec_err;

    always_comb begin
        drop_any = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (avm_cfg_readdatavalid[i] && !(resp_ok && (cur_sel == SEL_W'(i))))
                drop_any = 1'b1;
        end
    end

    always_comb begin
        avm_cfg_read  = '0;
        avm_cfg_write = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel == SEL_W'(i)) begin
                avm_cfg_write[i] = avs_config_write;
                avm_cfg_read[i]  = rd & ~rd_stall;
            end
        end
    end

    always_comb begin
        if (rd && rd_stall)
            avs_config_waitrequest = 1'b1;
        else if (dec_err)
            avs_config_waitrequest = 1'b0;
        else
            avs_config_waitrequest = slv_wait;
    end

    assign avm_cfg_address   = {NUM_SLAVES{loc_addr}};
    assign avm_cfg_writedata = avs_config_writedata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (slv_issue) next_state = BUSY;
            BUSY:    if (wd_fire)
                         next_state = FLUSH;
                     else if ((pend_cnt == PEND_W'(1)) && pend_dec && !slv_issue)
                         next_state = IDLE;
            FLUSH:   if (pend_cnt == PEND_W'(1)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_cnt <= '0;
            cur_sel  <= '0;
            rdv_q    <= 1'b0;
            rdata_q  <= '0;
            drop_cnt <= '0;
        end else begin
            if (slv_issue) cur_sel <= sel;
            if (slv_issue && !pend_dec)
                pend_cnt <= pend_cnt + PEND_W'(1);
            else if (!slv_issue && pend_dec)
                pend_cnt <= pend_cnt - PEND_W'(1);
            rdv_q <= resp_ok | flush_resp | err_issue;
            if (resp_ok)
                rdata_q <= cur_rdata;
            else if (flush_resp || err_issue)
                rdata_q <= ERR_DATA;
            if (drop_any && (drop_cnt != 8'hFF))
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign avs_config_readdatavalid = rdv_q;
    assign avs_config_readdata      = rdata_q;
    assign drop_count               = drop_cnt;

`ifdef CFG_FABRIC_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt;
    logic [7:0]      timeout_cnt;

    // Fires on the TIMEOUT-th consecutive BUSY cycle without issue or response.
    assign wd_fire = (state == BUSY) && !slv_issue && !resp_ok
                   && (wd_cnt == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt      <= '0;
            timeout_cnt <= '0;
        end else begin
            if (slv_issue || resp_ok || (state != BUSY))
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + WD_W'(1);
            if (wd_fire && (timeout_cnt != 8'hFF))
                timeout_cnt <= timeout_cnt + 8'd1;
        end
    end

    assign timeout_count = timeout_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign wd_fire        = 1'b0;
    assign timeout_count  = '0;
`endif

endmodule

// File: tb/tb_cfg_fabric.sv
module tb_cfg_fabric;
    localparam int LW = 12;
    localparam logic [31:0] ERR = 32'hBAD0_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] avs_config_address;
    logic        avs_config_read;
    logic        avs_config_write;
    logic [31:0] avs_config_writedata;
    logic        avs_config_waitrequest;
    logic [31:0] avs_config_readdata;
    logic        avs_config_readdatavalid;
    logic [23:0] avm_cfg_address;
    logic [1:0]  avm_cfg_read;
    logic [1:0]  avm_cfg_write;
    logic [31:0] avm_cfg_writedata;
    logic [1:0]  avm_cfg_waitrequest;
    logic [63:0] avm_cfg_readdata;
    logic [1:0]  avm_cfg_readdatavalid;
    logic [7:0]  timeout_count;
    logic [7:0]  drop_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cfg_fabric #(
        .NUM_SLAVES(2), .ADDR_W(16), .SEL_W(4), .DATA_W(32),
        .MAX_PEND(4), .TIMEOUT(8), .ERR_DATA(32'hBAD0_0000)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .avs_config_address       (avs_config_address),
        .avs_config_read          (avs_config_read),
        .avs_config_write         (avs_config_write),
        .avs_config_writedata     (avs_config_writedata),
        .avs_config_waitrequest   (avs_config_waitrequest),
        .avs_config_readdata      (avs_config_readdata),
        .avs_config_readdatavalid (avs_config_readdatavalid),
        .avm_cfg_address          (avm_cfg_address),
        .avm_cfg_read             (avm_cfg_read),
        .avm_cfg_write            (avm_cfg_write),
        .avm_cfg_writedata        (avm_cfg_writedata),
        .avm_cfg_waitrequest      (avm_cfg_waitrequest),
        .avm_cfg_readdata         (avm_cfg_readdata),
        .avm_cfg_readdatavalid    (avm_cfg_readdatavalid),
        .timeout_count            (timeout_count),
        .drop_count               (drop_count)
    );

    task automatic idle_inputs;
        avs_config_address    = '0;
        avs_config_read       = 1'b0;
        avs_config_write      = 1'b0;
        avs_config_writedata  = '0;
        avm_cfg_waitrequest   = '0;
        avm_cfg_readdata      = '0;
        avm_cfg_readdatavalid = '0;
    endtask

    task automatic apply_reset;
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        vectors++;
        if (avs_config_readdatavalid !== 1'b0) begin
            miscompares++; $display("FAIL reset_rdv: got %b want 0", avs_config_readdatavalid);
        end
        vectors++;
        if (avs_config_readdata !== 32'h0) begin
            miscompares++; $display("FAIL reset_rdata: got %h want 00000000", avs_config_readdata);
        end
        vectors++;
        if (timeout_count !== 8'd0 || drop_count !== 8'd0) begin
            miscompares++; $display("FAIL reset_counts: got %0d/%0d want 0/0", timeout_count, drop_count);
        end
        vectors++;
        if (avs_config_waitrequest !== 1'b0) begin
            miscompares++; $display("FAIL reset_wait: got %b want 0", avs_config_waitrequest);
        end
        reset = 1'b0;
    endtask

    task automatic test_write;
        @(negedge clk);
        avs_config_address   = 16'h1004;
        avs_config_write     = 1'b1;
        avs_config_writedata = 32'h1234;
        #1;
        vectors++;
        if (avm_cfg_write !== 2'b10 || avm_cfg_read !== 2'b00) begin
            miscompares++; $display("FAIL wr_strobe: got w=%b r=%b want w=10 r=00", avm_cfg_write, avm_cfg_read);
        end
        vectors++;
        if (avm_cfg_address[2*LW-1:LW] !== 12'h004 || avm_cfg_writedata !== 32'h1234) begin
            miscompares++; $display("FAIL wr_addr_data: got %h/%h want 004/00001234",
                                    avm_cfg_address[2*LW-1:LW], avm_cfg_writedata);
        end
        vectors++;
        if (avs_config_waitrequest !== 1'b0) begin
            miscompares++; $display("FAIL wr_wait: got %b want 0", avs_config_waitrequest);
        end
        // Read and write together: write wins.
        @(negedge clk);
        avs_config_read = 1'b1;
        #1;
        vectors++;
        if (avm_cfg_write !== 2'b10 || avm_cfg_read !== 2'b00) begin
            miscompares++; $display("FAIL wr_over_rd: got w=%b r=%b want w=10 r=00", avm_cfg_write, avm_cfg_read);
        end
        // Slave stall propagates to the master.
        @(negedge clk);
        avs_config_read     = 1'b0;
        avm_cfg_waitrequest = 2'b10;
        #1;
        vectors++;
        if (avs_config_waitrequest !== 1'b1) begin
            miscompares++; $display("FAIL wr_slave_wait: got %b want 1", avs_config_waitrequest);
        end
        // Decode-error write: accepted, no strobe anywhere.
        @(negedge clk);
        avm_cfg_waitrequest = 2'b00;
        avs_config_address  = 16'h7000;
        #1;
        vectors++;
        if (avm_cfg_write !== 2'b00 || avs_config_waitrequest !== 1'b0) begin
            miscompares++; $display("FAIL wr_decode_err: got w=%b wait=%b want w=00 wait=0",
                                    avm_cfg_write, avs_config_waitrequest);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_pipelined_reads;
        logic        tab_v [8];
        logic [31:0] tab_d [8];
        logic        prev_v;
        logic [31:0] prev_d;
        logic [11:0] exp_a;
        tab_v = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tab_d = '{32'hA, 32'h0, 32'hB, 32'hC, 32'h0, 32'hD, 32'h0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            avs_config_read    = 1'b1;
            avs_config_address = 16'h0010 + 16'(i);
            exp_a = 12'h010 + 12'(i);
            #1;
            vectors++;
            if (avs_config_waitrequest !== 1'b0 || avm_cfg_read !== 2'b01
                || avm_cfg_address[LW-1:0] !== exp_a) begin
                miscompares++; $display("FAIL rd_issue%0d: got wait=%b r=%b a=%h want 0/01/%h",
                                        i, avs_config_waitrequest, avm_cfg_read, avm_cfg_address[LW-1:0], exp_a);
            end
        end
        @(negedge clk);
        avs_config_address = 16'h0020;
        #1;
        vectors++;
        if (avs_config_waitrequest !== 1'b1 || avm_cfg_read !== 2'b00) begin
            miscompares++; $display("FAIL rd_full_stall: got wait=%b r=%b want 1/00",
                                    avs_config_waitrequest, avm_cfg_read);
        end
        prev_v = 1'b0;
        prev_d = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            vectors++;
            if (avs_config_readdatavalid !== prev_v
                || (prev_v && avs_config_readdata !== prev_d)) begin
                miscompares++; $display("FAIL rd_resp%0d: got v=%b d=%h want v=%b d=%h",
                                        k, avs_config_readdatavalid, avs_config_readdata, prev_v, prev_d);
            end
            avs_config_read       = 1'b0;
            avm_cfg_readdatavalid = {1'b0, tab_v[k]};
            avm_cfg_readdata      = {32'h0, tab_d[k]};
            prev_v = tab_v[k];
            prev_d = tab_d[k];
        end
        @(negedge clk);
        vectors++;
        if (drop_count !== 8'd0) begin
            miscompares++; $display("FAIL rd_no_drop: got %0d want 0", drop_count);
        end
        idle_inputs();
    endtask

    task automatic test_slave_switch;
        @(negedge clk);
        avs_config_read    = 1'b1;
        avs_config_address = 16'h0008;
        #1;
        vectors++;
        if (avm_cfg_read !== 2'b01 || avs_config_waitrequest !== 1'b0) begin
            miscompares++; $display("FAIL sw_first: got r=%b wait=%b want 01/0", avm_cfg_read, avs_config_waitrequest);
        end
        @(negedge clk);
        avs_config_address    = 16'h1008;
        avm_cfg_readdatavalid = 2'b01;
        avm_cfg_readdata      = {32'h0, 32'h55};
        #1;
        vectors++;
        if (avm_cfg_read !== 2'b00 || avs_config_waitrequest !== 1'b1) begin
            miscompares++; $display("FAIL sw_stall: got r=%b wait=%b want 00/1", avm_cfg_read, avs_config_waitrequest);
        end
        @(negedge clk);
        vectors++;
        if (avs_config_readdatavalid !== 1'b1 || avs_config_readdata !== 32'h55) begin
            miscompares++; $display("FAIL sw_resp0: got v=%b d=%h want 1/00000055",
                                    avs_config_readdatavalid, avs_config_readdata);
        end
        avm_cfg_readdatavalid = 2'b00;
        #1;
        vectors++;
        if (avm_cfg_read !== 2'b10 || avs_config_waitrequest !== 1'b0) begin
            miscompares++; $display("FAIL sw_release: got r=%b wait=%b want 10/0", avm_cfg_read, avs_config_waitrequest);
        end
        @(negedge clk);
        avs_config_read       = 1'b0;
        avm_cfg_readdatavalid = 2'b10;
        avm_cfg_readdata      = {32'h66, 32'h0};
        @(negedge clk);
        avm_cfg_readdatavalid = 2'b00;
        vectors++;
        if (avs_config_readdatavalid !== 1'b1 || avs_config_readdata !== 32'h66) begin
            miscompares++; $display("FAIL sw_resp1: got v=%b d=%h want 1/00000066",
                                    avs_config_readdatavalid, avs_config_readdata);
        end
        idle_inputs();
    endtask

    task automatic test_decode_error;
        @(negedge clk);
        avs_config_read    = 1'b1;
        avs_config_address = 16'h5000;
        #1;
        vectors++;
        if (avs_config_waitrequest !== 1'b0 || avm_cfg_read !== 2'b00) begin
            miscompares++; $display("FAIL de_issue: got wait=%b r=%b want 0/00", avs_config_waitrequest, avm_cfg_read);
        end
        @(negedge clk);
        avs_config_read = 1'b0;
        vectors++;
        if (avs_config_readdatavalid !== 1'b1 || avs_config_readdata !== ERR) begin
            miscompares++; $display("FAIL de_resp: got v=%b d=%h want 1/%h",
                                    avs_config_readdatavalid, avs_config_readdata, ERR);
        end
        @(negedge clk);
        vectors++;
        if (avs_config_readdatavalid !== 1'b0) begin
            miscompares++; $display("FAIL de_single: got v=%b want 0", avs_config_readdatavalid);
        end
        idle_inputs();
    endtask

    task automatic test_reset_and_stray;
        @(negedge clk);
        avs_config_read    = 1'b1;
        avs_config_address = 16'h1000;
        #1;
        vectors++;
        if (avm_cfg_read !== 2'b10) begin
            miscompares++; $display("FAIL st_issue: got r=%b want 10", avm_cfg_read);
        end
        @(negedge clk);
        avs_config_read = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        avm_cfg_readdatavalid = 2'b10;
        avm_cfg_readdata      = {32'h77, 32'h0};
        @(negedge clk);
        avm_cfg_readdatavalid = 2'b00;
        vectors++;
        if (avs_config_readdatavalid !== 1'b0) begin
            miscompares++; $display("FAIL st_no_resp: got v=%b want 0", avs_config_readdatavalid);
        end
        vectors++;
        if (drop_count !== 8'd1) begin
            miscompares++; $display("FAIL st_drop: got %0d want 1", drop_count);
        end
        idle_inputs();
    endtask

    task automatic test_timeout;
        int seen;
        apply_reset();
        @(negedge clk);
        avs_config_read    = 1'b1;
        avs_config_address = 16'h0000;
        @(negedge clk);
        avs_config_address = 16'h0004;
        @(negedge clk);
        avs_config_read = 1'b0;
`ifdef CFG_FABRIC_TIMEOUT_EN
        seen = 0;
        for (int k = 3; k <= 10; k++) begin
            @(negedge clk);
            if (avs_config_readdatavalid !== 1'b0) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++; $display("FAIL to_early: got %0d early responses want 0", seen);
        end
        @(negedge clk);
        vectors++;
        if (avs_config_readdatavalid !== 1'b1 || avs_config_readdata !== ERR) begin
            miscompares++; $display("FAIL to_resp1: got v=%b d=%h want 1/%h",
                                    avs_config_readdatavalid, avs_config_readdata, ERR);
        end
        avs_config_read = 1'b1;
        #1;
        vectors++;
        if (avs_config_waitrequest !== 1'b1 || avm_cfg_read !== 2'b00) begin
            miscompares++; $display("FAIL to_flush_stall: got wait=%b r=%b want 1/00",
                                    avs_config_waitrequest, avm_cfg_read);
        end
        @(negedge clk);
        avs_config_read = 1'b0;
        vectors++;
        if (avs_config_readdatavalid !== 1'b1 || avs_config_readdata !== ERR) begin
            miscompares++; $display("FAIL to_resp2: got v=%b d=%h want 1/%h",
                                    avs_config_readdatavalid, avs_config_readdata, ERR);
        end
        vectors++;
        if (timeout_count !== 8'd1) begin
            miscompares++; $display("FAIL to_count: got %0d want 1", timeout_count);
        end
        @(negedge clk);
        vectors++;
        if (avs_config_readdatavalid !== 1'b0) begin
            miscompares++; $display("FAIL to_done: got v=%b want 0", avs_config_readdatavalid);
        end
        avm_cfg_readdatavalid = 2'b01;
        avm_cfg_readdata      = {32'h0, 32'h99};
        @(negedge clk);
        avm_cfg_readdatavalid = 2'b00;
        vectors++;
        if (avs_config_readdatavalid !== 1'b0 || drop_count !== 8'd1) begin
            miscompares++; $display("FAIL to_late_drop: got v=%b drop=%0d want 0/1",
                                    avs_config_readdatavalid, drop_count);
        end
`else
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (avs_config_readdatavalid !== 1'b0) seen++;
        end
        vectors++;
        if (seen != 0 || timeout_count !== 8'd0) begin
            miscompares++; $display("FAIL nt_wait: got %0d responses tc=%0d want 0/0", seen, timeout_count);
        end
        avm_cfg_readdatavalid = 2'b01;
        avm_cfg_readdata      = {32'h0, 32'h1};
        @(negedge clk);
        avm_cfg_readdata      = {32'h0, 32'h2};
        vectors++;
        if (avs_config_readdatavalid !== 1'b1 || avs_config_readdata !== 32'h1) begin
            miscompares++; $display("FAIL nt_resp1: got v=%b d=%h want 1/00000001",
                                    avs_config_readdatavalid, avs_config_readdata);
        end
        @(negedge clk);
        avm_cfg_readdatavalid = 2'b00;
        vectors++;
        if (avs_config_readdatavalid !== 1'b1 || avs_config_readdata !== 32'h2) begin
            miscompares++; $display("FAIL nt_resp2: got v=%b d=%h want 1/00000002",
                                    avs_config_readdatavalid, avs_config_readdata);
        end
        @(negedge clk);
        vectors++;
        if (avs_config_readdatavalid !== 1'b0 || drop_count !== 8'd0 || timeout_count !== 8'd0) begin
            miscompares++; $display("FAIL nt_done: got v=%b drop=%0d tc=%0d want 0/0/0",
                                    avs_config_readdatavalid, drop_count, timeout_count);
        end
`endif
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write();
        test_pipelined_reads();
        test_slave_switch();
        test_decode_error();
        test_reset_and_stray();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_time_limit: got no completion want completion");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/cfg_fabric.md
# cfg_fabric

Parametrised configuration-bus interconnect that splits a single Avalon-MM config slave port across NUM_SLAVES downstream config slaves by address decode. It replaces wired-OR sharing of readdata/readdatavalid with proper per-slave select, in-order read-response routing, stall on slave switch and a read-timeout watchdog. It sits between the HPS config master and the MemoryAccess, Controller and future config-mapped units.

## Interface
- NUM_SLAVES, 2: number of downstream slaves, 1..16
- ADDR_W, 16: master address width
- SEL_W, 4: upper address bits used as slave index
- DATA_W, 32: data width
- MAX_PEND, 4: maximum outstanding reads, ≥1
- TIMEOUT, 255: idle cycles with reads outstanding before watchdog fires
- ERR_DATA, 32'hBAD0_0000: readdata returned for decode errors and timeouts

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- avs_config_address  in  ADDR_W  master address
- avs_config_read / avs_config_write  in  1  master strobes
- avs_config_writedata  in  DATA_W
- avs_config_waitrequest  out  1  stall to master
- avs_config_readdata  out  DATA_W  registered response data
- avs_config_readdatavalid  out  1  registered response strobe
- avm_cfg_address  out  NUM_SLAVES*(ADDR_W-SEL_W)  per-slave local address (low bits)
- avm_cfg_read / avm_cfg_write  out  NUM_SLAVES  per-slave strobes
- avm_cfg_writedata  out  DATA_W  broadcast
- avm_cfg_waitrequest  in  NUM_SLAVES
- avm_cfg_readdata  in  NUM_SLAVES*DATA_W
- avm_cfg_readdatavalid  in  NUM_SLAVES
- timeout_count  out  8  saturating watchdog-fire count
- drop_count  out  8  saturating count of dropped slave responses

## Operation
- sel = avs_config_address[ADDR_W-1 -: SEL_W]; sel ≥ NUM_SLAVES is a decode error.
- read and write both high: write wins, read ignored.
- Writes: routed combinationally to slave sel; never stalled by outstanding reads; decode-error writes accepted (waitrequest 0) and discarded.
- Reads tracked by pend_cnt (0..MAX_PEND) and cur_sel.
- Read stall (waitrequest=1, slave strobe suppressed) when: pend_cnt==MAX_PEND; or pend_cnt>0 and sel≠cur_sel; or state FLUSH.
- Otherwise slave read = master read & (sel match); waitrequest = avm_cfg_waitrequest[sel]. Issue occurs when read & !waitrequest: pend_cnt++, cur_sel←sel.
- Decode-error read: only issued when pend_cnt==0; responds internally with ERR_DATA next cycle.
- Response: avm_cfg_readdatavalid[cur_sel] with pend_cnt>0 → forward data, pend_cnt--. readdatavalid from any other slave, or with pend_cnt==0, dropped; drop_count++.
- Issue and response in same cycle: pend_cnt unchanged.
- States: IDLE (pend_cnt==0), BUSY (pend_cnt>0), FLUSH.
- Watchdog: counter clears on issue or response; in BUSY increments each cycle; at TIMEOUT → FLUSH, timeout_count++.
- FLUSH: one ERR_DATA response per cycle, pend_cnt-- each, slave responses dropped (counted); pend_cnt==0 → IDLE.
- Late responses after FLUSH that collide with new reads to the same slave are indistinguishable; this is a documented limitation.

## Timing
- Reset values: readdatavalid 0, readdata 0, pend_cnt 0, state IDLE, watchdog 0, both counters 0. Waitrequest follows its combinational rule.
- Read-response latency: slave readdatavalid → master readdatavalid exactly 1 cycle; decode-error read → response 1 cycle after issue.
- Write and read request path: zero latency, combinational.
- Reset mid-transaction: all outstanding reads are forgotten; subsequent stray slave responses are dropped and counted.
- Counters saturate at 255.

## Configuration
- CFG_FABRIC_TIMEOUT_EN defined: watchdog and FLUSH state present as above.
- Undefined: no watchdog, FLUSH unreachable, reads wait indefinitely, timeout_count tied 0.

## Test plan
- NUM_SLAVES=2, write 0x1234 to addr 0x1004 → avm_cfg_write[1]=1 with address 0x004 and data 0x1234; slave 0 untouched.
- 4 reads to slave 0, slave returns 0xA..0xD over later cycles → 4 master responses, each 1 cycle after the slave's, in order; a 5th read stalls while pend_cnt=4.
- Read slave 0 pending, then read slave 1 → waitrequest held until slave-0 response, then the slave-1 read issues.
- Read addr 0x5000 (sel 5) → ERR_DATA with valid 1 cycle later; no slave strobe.
- With CFG_FABRIC_TIMEOUT_EN and TIMEOUT=8, 2 reads unanswered → after 8 cycles 2 consecutive ERR_DATA responses, timeout_count=1; a late slave response increments drop_count to 1.
- Slave 1 asserts readdatavalid with no read outstanding → no master response, drop_count=1.
